// File: rtl/decimal_countdown_pkg.sv
// Shared definitions for the four-digit BCD round-timer countdown:
// FSM state encoding, BCD digit limits and the digit clamp helper.
package decimal_countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/decimal_down_unit.sv
// One BCD digit of the countdown: clamped load, decrement with 0->9 wrap.
// Value updates on the clock edge after load/enable; borrow_out is combinational.
module decimal_down_unit
  import decimal_countdown_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic [3:0] value,
  output logic       borrow_out
);

  logic [3:0] value_q;
  logic [3:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = bcd_clamp(load_value);
    end else if (enable) begin
      value_d = (value_q == BCD_ZERO) ? BCD_MAX : value_q - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value_q <= BCD_ZERO;
    end else begin
      value_q <= value_d;
    end
  end

  assign value      = value_q;
  assign borrow_out = enable && (value_q == BCD_ZERO);

endmodule

// File: rtl/decimal_countdown.sv
// Four-digit BCD round timer: load/start/pause FSM over a chain of digit units.
// All outputs registered; value and flags update one edge after the qualifying input.
module decimal_countdown
  import decimal_countdown_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       load,
  input  logic [3:0] L3,
  input  logic [3:0] L2,
  input  logic [3:0] L1,
  input  logic [3:0] L0,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] V3,
  output logic [3:0] V2,
  output logic [3:0] V1,
  output logic [3:0] V0,
  output logic       running,
  output logic       done,
  output logic       expired
);

  state_e state_q, state_d;
  logic   running_q, running_d;
  logic   done_q, done_d;
  logic   expired_q, expired_d;

  logic   tick;
  logic   borrow_0, borrow_1, borrow_2;
  logic   msd_borrow_unused;
  logic   value_is_zero;
  logic   value_is_one;

  // Load and pause both outrank the tick, so a dropped tick never reaches the digits.
  assign tick = enable && !load && !pause && (state_q == ST_RUNNING);

  decimal_down_unit u_digit0 (
    .clock      (clock),
    .reset      (reset),
    .enable     (tick),
    .load       (load),
    .load_value (L0),
    .value      (V0),
    .borrow_out (borrow_0)
  );

  decimal_down_unit u_digit1 (
    .clock      (clock),
    .reset      (reset),
    .enable     (borrow_0),
    .load       (load),
    .load_value (L1),
    .value      (V1),
    .borrow_out (borrow_1)
  );

  decimal_down_unit u_digit2 (
    .clock      (clock),
    .reset      (reset),
    .enable     (borrow_1),
    .load       (load),
    .load_value (L2),
    .value      (V2),
    .borrow_out (borrow_2)
  );

  // The top digit never borrows: a zero value leaves RUNNING before it could underflow.
  decimal_down_unit u_digit3 (
    .clock      (clock),
    .reset      (reset),
    .enable     (borrow_2),
    .load       (load),
    .load_value (L3),
    .value      (V3),
    .borrow_out (msd_borrow_unused)
  );

  assign value_is_zero = (V3 == BCD_ZERO) && (V2 == BCD_ZERO) &&
                         (V1 == BCD_ZERO) && (V0 == BCD_ZERO);
  assign value_is_one  = (V3 == BCD_ZERO) && (V2 == BCD_ZERO) &&
                         (V1 == BCD_ZERO) && (V0 == 4'd1);

  always_comb begin
    state_d   = state_q;
    expired_d = 1'b0;
    if (load) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !pause && !value_is_zero) state_d = ST_RUNNING;
        end
        ST_RUNNING: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (enable && value_is_one) begin
            state_d   = ST_EXPIRED;
            expired_d = 1'b1;
          end
        end
        ST_PAUSED: begin
          if (start && !pause) state_d = ST_RUNNING;
        end
        ST_EXPIRED: begin
          state_d = ST_EXPIRED;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    running_d = (state_d == ST_RUNNING);
    done_d    = (state_d == ST_EXPIRED);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  assign running = running_q;
  assign done    = done_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_decimal_countdown.sv
// Bench for decimal_countdown: integer-valued reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_decimal_countdown;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] L3 = 4'd0, L2 = 4'd0, L1 = 4'd0, L0 = 4'd0;
  logic [3:0] V3, V2, V1, V0;
  logic       running, done, expired;
  logic [19:0] dut_o;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  decimal_countdown dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .load    (load),
    .L3      (L3),
    .L2      (L2),
    .L1      (L1),
    .L0      (L0),
    .start   (start),
    .pause   (pause),
    .V3      (V3),
    .V2      (V2),
    .V1      (V1),
    .V0      (V0),
    .running (running),
    .done    (done),
    .expired (expired)
  );

  assign dut_o = {V3, V2, V1, V0, running, done, expired};

  // Reference model: value as a plain integer, state as 0 idle/1 run/2 pause/3 expired.
  int m_val = 0;
  int m_st  = 0;
  bit m_exp = 1'b0;
  bit cmp_en = 1'b0;

  function automatic int clampd(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [19:0] ex(input logic [15:0] v, input logic r, input logic d,
                                     input logic e);
    return {v, r, d, e};
  endfunction

  always @(negedge reset) begin
    m_val = 0;
    m_st  = 0;
    m_exp = 1'b0;
  end

  always @(posedge clock) begin
    m_exp = 1'b0;
    if (!reset) begin
      m_val = 0;
      m_st  = 0;
    end else if (load) begin
      m_val = clampd(L3) * 1000 + clampd(L2) * 100 + clampd(L1) * 10 + clampd(L0);
      m_st  = 0;
    end else begin
      case (m_st)
        0: if (start && !pause && m_val != 0) m_st = 1;
        1: begin
          if (pause) begin
            m_st = 2;
          end else if (enable) begin
            m_val = m_val - 1;
            if (m_val == 0) begin
              m_st  = 3;
              m_exp = 1'b1;
            end
          end
        end
        2: if (start && !pause) m_st = 1;
        default: m_st = 3;
      endcase
    end
  end

  always @(negedge clock) begin
    logic [19:0] exp_o;
    if (cmp_en) begin
      exp_o = {to_bcd(m_val), m_st == 1, m_st == 3, m_exp};
      checks++;
      if (dut_o !== exp_o) begin
        errors++;
        $display("FAIL model_cmp t=%0t: got %h expected %h", $time, dut_o, exp_o);
      end
    end
  end

  task automatic chk(input string name, input logic [19:0] got, input logic [19:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Drive one cycle of inputs starting just after a rising edge; returns 1ns after the next.
  task automatic cyc(input logic e, input logic ld, input logic st, input logic ps,
                     input logic [15:0] lv);
    enable = e;
    load   = ld;
    start  = st;
    pause  = ps;
    {L3, L2, L1, L0} = lv;
    @(posedge clock);
    #1;
    enable = 1'b0;
    load   = 1'b0;
    start  = 1'b0;
    pause  = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] lv);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, lv);
  endtask

  task automatic do_start();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
  endtask

  task automatic do_tick();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("reset_state", dut_o, ex(16'h0000, 1'b0, 1'b0, 1'b0));
    cmp_en = 1'b1;
    reset  = 1'b1;

    // Async reset mid-count, observed before any further clock edge.
    do_load(16'h0420);
    do_start();
    chk("run_0420", dut_o, ex(16'h0420, 1'b1, 1'b0, 1'b0));
    #2 reset = 1'b0;
    #1 chk("async_reset", dut_o, ex(16'h0000, 1'b0, 1'b0, 1'b0));
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (3) do_tick();
    chk("reset_no_count", dut_o, ex(16'h0000, 1'b0, 1'b0, 1'b0));

    // Borrow across digits.
    do_load(16'h0100);
    do_start();
    do_tick();
    chk("borrow_0100", dut_o, ex(16'h0099, 1'b1, 1'b0, 1'b0));
    do_load(16'h1000);
    do_start();
    chk("start_1000", dut_o, ex(16'h1000, 1'b1, 1'b0, 1'b0));
    do_tick();
    chk("borrow_1000", dut_o, ex(16'h0999, 1'b1, 1'b0, 1'b0));

    // Expiry and the one-cycle pulse.
    do_load(16'h0002);
    do_start();
    do_tick();
    chk("exp_0001", dut_o, ex(16'h0001, 1'b1, 1'b0, 1'b0));
    do_tick();
    chk("exp_pulse", dut_o, ex(16'h0000, 1'b0, 1'b1, 1'b1));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("exp_fall", dut_o, ex(16'h0000, 1'b0, 1'b1, 1'b0));
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    chk("exp_hold", dut_o, ex(16'h0000, 1'b0, 1'b1, 1'b0));

    // Clamping and zero start.
    do_load(16'hC3F0);
    chk("clamp", dut_o, ex(16'h9390, 1'b0, 1'b0, 1'b0));
    do_load(16'h0000);
    do_start();
    do_tick();
    chk("zero_start", dut_o, ex(16'h0000, 1'b0, 1'b0, 1'b0));

    // Pause priority and resume.
    do_load(16'h0050);
    do_start();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    chk("pause_tick", dut_o, ex(16'h0050, 1'b0, 1'b0, 1'b0));
    repeat (3) do_tick();
    chk("paused_hold", dut_o, ex(16'h0050, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    chk("start_and_pause", dut_o, ex(16'h0050, 1'b0, 1'b0, 1'b0));
    do_start();
    chk("resume", dut_o, ex(16'h0050, 1'b1, 1'b0, 1'b0));
    do_tick();
    chk("resume_tick", dut_o, ex(16'h0049, 1'b1, 1'b0, 1'b0));

    // Load overrides a same-cycle tick.
    do_load(16'h0007);
    do_start();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0300);
    chk("load_override", dut_o, ex(16'h0300, 1'b0, 1'b0, 1'b0));

    // Full-range count: 9999 expires on exactly the 9999th back-to-back tick.
    do_load(16'h9999);
    do_start();
    repeat (9998) do_tick();
    chk("full_9998", dut_o, ex(16'h0001, 1'b1, 1'b0, 1'b0));
    do_tick();
    chk("full_9999", dut_o, ex(16'h0000, 1'b0, 1'b1, 1'b1));

    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
